// File: rtl/instr_pkg.sv
// Shared encodings for the instruction encoder: format codes, field positions
// and the load-controller state encoding.
package instr_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_JI  = 2'd2,
      FMT_JII = 2'd3
   } fmt_e;

   localparam int OPC_LSB   = 27;
   localparam int RD_LSB    = 22;
   localparam int RS_LSB    = 17;
   localparam int RT_LSB    = 12;
   localparam int SHAMT_LSB = 7;
   localparam int ALUOP_LSB = 2;

   localparam int IMM_W = 17;
   localparam int TGT_W = 27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO that buffers packed words between the host and imem.
// The flush input empties it in one cycle; the storage array itself is not reset.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // The pointers carry one extra wrap bit so that full and empty can be told apart.
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rdata = mem[rd_ptr_r[AW-1:0]];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs per-field instruction descriptions into 32-bit words and streams them to imem.
// Optional immediate range checking is enabled by defining INSTR_ENC_IMM_CHECK_EN.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int                DEPTH     = 8,
   parameter int                ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              prog_start,
   input  logic              prog_end,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_shamt,
   input  logic [4:0]        in_alu_op,
   input  logic [31:0]       in_imm,
   input  logic [26:0]       in_target,
   input  logic              imem_stall,
   output logic              imem_wren,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   output logic              done,
   output logic              addr_ovf,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   state_e            state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   count_r;
   logic              addr_ovf_r;
   logic              done_r;
   logic              imem_wren_r;
   logic [ADDR_W-1:0] imem_addr_r;
   logic [31:0]       imem_data_r;

   logic              accept;
   logic              imm_bad;
   logic              push;
   logic              pop;
   logic              flush;
   logic              full;
   logic              empty;
   logic [31:0]       packed_word;
   logic [31:0]       fifo_rdata;

   function automatic logic [31:0] pack_word(
      input logic [1:0]       fmt,
      input logic [4:0]       opc,
      input logic [4:0]       rd,
      input logic [4:0]       rs,
      input logic [4:0]       rt,
      input logic [4:0]       shamt,
      input logic [4:0]       alu_op,
      input logic [IMM_W-1:0] imm,
      input logic [TGT_W-1:0] tgt
   );
      logic [31:0] w;
      w = 32'd0;
      w[OPC_LSB +: 5] = opc;
      case (fmt_e'(fmt))
         FMT_R: begin
            w[RD_LSB +: 5]    = rd;
            w[RS_LSB +: 5]    = rs;
            w[RT_LSB +: 5]    = rt;
            w[SHAMT_LSB +: 5] = shamt;
            w[ALUOP_LSB +: 5] = alu_op;
         end
         FMT_I: begin
            w[RD_LSB +: 5]  = rd;
            w[RS_LSB +: 5]  = rs;
            w[IMM_W-1:0]    = imm;
         end
         FMT_JI: begin
            w[TGT_W-1:0] = tgt;
         end
         FMT_JII: begin
            w[RD_LSB +: 5] = rd;
         end
         default: begin
            w = 32'd0;
         end
      endcase
      return w;
   endfunction

   assign packed_word = pack_word(in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt,
                                  in_alu_op, in_imm[IMM_W-1:0], in_target);

   assign in_ready = (state_r == ST_LOAD) & ~full & ~addr_ovf_r;
   assign accept   = in_valid & in_ready;
   assign push     = accept & ~imm_bad;
   // Once the address space is exhausted the remaining buffered words are dropped.
   assign flush    = prog_start | addr_ovf_r;
   assign pop      = ~empty & ~imem_stall & ~addr_ovf_r & ~prog_start;

`ifdef INSTR_ENC_IMM_CHECK_EN
   logic err_r;

   // An I-type immediate fits in 17 signed bits when bits [31:16] are a pure sign extension.
   assign imm_bad = (in_fmt == 2'(FMT_I)) &&
                    !((in_imm[31:16] == 16'h0000) || (in_imm[31:16] == 16'hFFFF));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else if (prog_start) begin
         err_r <= 1'b0;
      end else if (accept && imm_bad) begin
         err_r <= 1'b1;
      end
   end

   assign err = err_r;
`else
   logic unused_imm;

   assign imm_bad    = 1'b0;
   assign unused_imm = ^in_imm[31:IMM_W];
   assign err        = 1'b0;
`endif

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wdata   (packed_word),
      .rdata   (fifo_rdata),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         count_r     <= '0;
         addr_ovf_r  <= 1'b0;
         done_r      <= 1'b0;
         imem_wren_r <= 1'b0;
         imem_addr_r <= '0;
         imem_data_r <= 32'd0;
      end else begin
         imem_wren_r <= 1'b0;
         done_r      <= 1'b0;
         if (prog_start) begin
            state_r    <= ST_LOAD;
            addr_r     <= BASE_ADDR;
            count_r    <= '0;
            addr_ovf_r <= 1'b0;
         end else begin
            if (pop) begin
               imem_wren_r <= 1'b1;
               imem_addr_r <= addr_r;
               imem_data_r <= fifo_rdata;
               count_r     <= count_r + (ADDR_W+1)'(1);
               // The last address is written once; the counter parks there instead of wrapping.
               if (addr_r == {ADDR_W{1'b1}}) begin
                  addr_ovf_r <= 1'b1;
               end else begin
                  addr_r <= addr_r + ADDR_W'(1);
               end
            end
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_LOAD: begin
                  if (prog_end) begin
                     state_r <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (empty && !imem_wren_r) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign imem_wren = imem_wren_r;
   assign imem_addr = imem_addr_r;
   assign imem_data = imem_data_r;
   assign done      = done_r;
   assign addr_ovf  = addr_ovf_r;
   assign count     = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 12-bit-address instance and a 3-bit-address
// instance share the host-side stimulus; the monitor checks the selected one.
module tb_instr_encoder;
   import instr_pkg::*;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [4:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  sh;
      logic [4:0]  alu;
      logic [31:0] imm;
      logic [26:0] tgt;
   } word_t;

   logic        clock = 1'b0;
   logic        reset_n, prog_start, prog_end, in_valid, imem_stall;
   logic [1:0]  in_fmt;
   logic [4:0]  in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op;
   logic [31:0] in_imm;
   logic [26:0] in_target;

   logic        ready_a, wren_a, done_a, ovf_a, err_a;
   logic [11:0] addr_a;
   logic [31:0] data_a;
   logic [12:0] count_a;
   logic        ready_b, wren_b, done_b, ovf_b, err_b;
   logic [2:0]  addr_b;
   logic [31:0] data_b;
   logic [3:0]  count_b;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_addr = 0;
   bit          sel_b    = 1'b0;
   logic [31:0] sb[$];

   always #5 clock = ~clock;

   instr_encoder dut_a (
      .clock(clock), .reset_n(reset_n), .prog_start(prog_start), .prog_end(prog_end),
      .in_valid(in_valid), .in_ready(ready_a), .in_fmt(in_fmt), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
      .in_alu_op(in_alu_op), .in_imm(in_imm), .in_target(in_target),
      .imem_stall(imem_stall), .imem_wren(wren_a), .imem_addr(addr_a), .imem_data(data_a),
      .done(done_a), .addr_ovf(ovf_a), .err(err_a), .count(count_a)
   );

   instr_encoder #(.ADDR_W(3)) dut_b (
      .clock(clock), .reset_n(reset_n), .prog_start(prog_start), .prog_end(prog_end),
      .in_valid(in_valid), .in_ready(ready_b), .in_fmt(in_fmt), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
      .in_alu_op(in_alu_op), .in_imm(in_imm), .in_target(in_target),
      .imem_stall(imem_stall), .imem_wren(wren_b), .imem_addr(addr_b), .imem_data(data_b),
      .done(done_b), .addr_ovf(ovf_b), .err(err_b), .count(count_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] pack(input word_t w);
      logic [31:0] r;
      r = {w.opc, 27'd0};
      case (w.fmt)
         2'd0:    r[26:0] = {w.rd, w.rs, w.rt, w.sh, w.alu, 2'b00};
         2'd1:    r[26:0] = {w.rd, w.rs, w.imm[16:0]};
         2'd2:    r[26:0] = w.tgt;
         default: r[26:0] = {w.rd, 22'd0};
      endcase
      return r;
   endfunction

   function automatic word_t mk(input logic [1:0] fmt, input logic [4:0] opc, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                                input logic [4:0] alu, input logic [31:0] imm, input logic [26:0] tgt);
      word_t w;
      w = {fmt, opc, rd, rs, rt, sh, alu, imm, tgt};
      return w;
   endfunction

   function automatic word_t rand_word();
      word_t w;
      w = mk(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), 32'($urandom_range(0, 131071)) - 32'd65536, 27'($urandom));
      return w;
   endfunction

   // Scoreboard monitor: every write of the selected instance must match the queue head in order.
   always @(negedge clock) begin
      logic        wr;
      logic [31:0] ad, dt;
      wr = sel_b ? wren_b : wren_a;
      ad = sel_b ? 32'(addr_b) : 32'(addr_a);
      dt = sel_b ? data_b : data_a;
      if (wr) begin
         if (sb.size() == 0) begin
            check_val("unexpected_write", {31'd0, wr}, 32'd0);
         end else begin
            check_val("write_addr", ad, 32'(exp_addr));
            check_val("write_data", dt, sb.pop_front());
            exp_addr++;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start_prog();
      prog_start = 1'b1;
      step();
      prog_start = 1'b0;
      sb.delete();
      exp_addr = 0;
   endtask

   task automatic end_prog();
      prog_end = 1'b1;
      step();
      prog_end = 1'b0;
   endtask

   task automatic push(input word_t w, input bit exp_en, input logic [31:0] exp_data,
                       input int bound, output bit acc);
      {in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op, in_imm, in_target} = w;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < bound && !acc; i++) begin
         @(negedge clock);
         if (sel_b ? ready_b : ready_a) begin
            @(posedge clock);
            acc = 1'b1;
            if (exp_en) sb.push_back(exp_data);
            #1;
         end else begin
            @(posedge clock);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input word_t w, input logic [31:0] exp_data);
      bit acc;
      push(w, 1'b1, exp_data, 50, acc);
      check_val("push_accepted", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) step();
      step();
      step();
      check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic count_done(input string tag);
      int pulses;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (sel_b ? done_b : done_a) pulses++;
      end
      check_val(tag, 32'(pulses), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      word_t w;
      bit    acc;
      int    n_acc;
      reset_n = 1'b0; prog_start = 1'b0; prog_end = 1'b0; in_valid = 1'b0; imem_stall = 1'b0;
      {in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_alu_op, in_imm, in_target} = '0;
      repeat (3) step();
      @(negedge clock);
      check_val("rst_outputs", {ready_a, wren_a, done_a, ovf_a, err_a, 27'd0}, 32'd0);
      check_val("rst_addr_data_count", data_a | 32'(addr_a) | 32'(count_a), 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // 1: single R-type, one-cycle write latency
      start_prog();
      w = mk(2'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 32'd0, 27'd0);
      push_exp(w, pack(w));
      @(negedge clock);
      check_val("lat_before", {31'd0, wren_a}, 32'd0);
      @(negedge clock);
      check_val("lat_after", {31'd0, wren_a}, 32'd1);
      wait_drain();

      // 2: I / JI / JII back-to-back
      start_prog();
      push_exp(mk(2'd1, 5'd5, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 27'd0), 32'h2901FFFF);
      push_exp(mk(2'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h123), 32'h08000123);
      push_exp(mk(2'd3, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0), 32'h27C00000);
      wait_drain();
      check_val("count_three", 32'(count_a), 32'd3);
      end_prog();
      count_done("done_pulse_a");

      // 3: stall fills the FIFO, then release
      start_prog();
      imem_stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         w = rand_word();
         push_exp(w, pack(w));
      end
      @(negedge clock);
      check_val("ready_low_full", {31'd0, ready_a}, 32'd0);
      check_val("no_write_stall", 32'(count_a), 32'd0);
      step();
      imem_stall = 1'b0;
      w = rand_word();
      push_exp(w, pack(w));
      wait_drain();
      check_val("count_nine", 32'(count_a), 32'd9);
      check_val("addr_seq_end", 32'(exp_addr), 32'd9);

      // 4: address exhaustion on the 3-bit instance
      sel_b = 1'b1;
      start_prog();
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         w = rand_word();
         push(w, i < 8, pack(w), 3, acc);
         if (acc) n_acc++;
      end
      check_val("tenth_rejected", {31'd0, acc}, 32'd0);
      @(negedge clock);
      check_val("ovf_set", {31'd0, ovf_b}, 32'd1);
      check_val("ready_after_ovf", {31'd0, ready_b}, 32'd0);
      wait_drain();
      check_val("count_ovf", 32'(count_b), 32'd8);
      end_prog();
      count_done("done_pulse_b");
      sel_b = 1'b0;

      // 5: reset mid-burst discards buffered words
      start_prog();
      imem_stall = 1'b1;
      for (int i = 0; i < 4; i++) push(rand_word(), 1'b0, 32'd0, 5, acc);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      imem_stall = 1'b0;
      @(negedge clock);
      check_val("midrst_flags", {ready_a, wren_a, done_a, ovf_a, err_a, 27'd0}, 32'd0);
      check_val("midrst_addr_data_count", data_a | 32'(addr_a) | 32'(count_a), 32'd0);
      repeat (10) step();
      start_prog();
      w = rand_word();
      push_exp(w, pack(w));
      wait_drain();
      check_val("restart_count", 32'(count_a), 32'd1);

      // 6: out-of-range immediate
      start_prog();
      w = mk(2'd1, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0);
`ifdef INSTR_ENC_IMM_CHECK_EN
      push(w, 1'b0, 32'd0, 50, acc);
      check_val("bad_imm_accepted", {31'd0, acc}, 32'd1);
      repeat (3) step();
      check_val("err_set", {31'd0, err_a}, 32'd1);
      check_val("bad_imm_not_written", 32'(count_a), 32'd0);
      w = mk(2'd1, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 32'hFFFF_0000, 27'd0);
      push_exp(w, pack(w));
      wait_drain();
      check_val("err_sticky", {31'd0, err_a}, 32'd1);
`else
      push_exp(w, pack(w));
      wait_drain();
      check_val("err_tied_low", {31'd0, err_a}, 32'd0);
`endif
      check_val("final_count", 32'(count_a), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
